// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared states and constants for the boot program loader
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_HI,
        ST_HDR_LO,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam int HDR_BYTES   = 2;
    localparam int WORD_BYTES  = 4;
    localparam int INSTR_WIDTH = 32;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// rtl/prog_loader_word_assembler.sv - big-endian byte-to-word shift register
module word_assembler
    import prog_loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   shift_en,
    input  logic [7:0]             byte_in,
    output logic [INSTR_WIDTH-1:0] word,
    output logic                   word_full
);

    localparam int CW = $clog2(WORD_BYTES);

    logic [CW-1:0] byte_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (shift_en) begin
            word     <= {word[INSTR_WIDTH-9:0], byte_in};
            byte_cnt <= byte_cnt + 1'b1;
        end
    end

    // Asserted while the final byte of a word is being shifted in.
    assign word_full = shift_en && (byte_cnt == CW'(WORD_BYTES - 1));

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams a length-prefixed program into instruction memory, then releases the CPU
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [7:0]             byte_in,
    input  logic                   byte_valid,
    output logic                   byte_ready,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    output logic                   imem_we,
    output logic                   cpu_run,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [ADDR_WIDTH:0]    words_loaded
);

    localparam int              TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   T_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]     MAX_WORDS = 17'(2 ** ADDR_WIDTH);

    state_t                 state, next_state;
    logic [7:0]             n_hi;
    logic [15:0]            n_words;
    logic [15:0]            n_next;
    logic [ADDR_WIDTH:0]    wcount;
    logic [TW-1:0]          tcnt;
    logic                   in_load;
    logic                   accept;
    logic                   idle_tick;
    logic                   timed_out;
    logic                   restart;
    logic                   asm_full;
    logic [INSTR_WIDTH-1:0] asm_word;

    assign in_load   = (state == ST_HDR_HI) || (state == ST_HDR_LO) || (state == ST_DATA);
    assign accept    = in_load && byte_valid;
    assign idle_tick = in_load && !byte_valid;
    assign timed_out = idle_tick && (tcnt == T_LAST);
    assign n_next    = {n_hi, byte_in};

    word_assembler u_asm (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (restart || timed_out),
        .shift_en  (accept && (state == ST_DATA)),
        .byte_in   (byte_in),
        .word      (asm_word),
        .word_full (asm_full)
    );

    always_comb begin
        next_state = state;
        restart    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    next_state = ST_HDR_HI;
                    restart    = 1'b1;
                end
            end
            ST_HDR_HI: begin
                if (accept)         next_state = ST_HDR_LO;
                else if (timed_out) next_state = ST_ERROR;
            end
            ST_HDR_LO: begin
                if (accept) begin
                    if (n_next == 16'd0)                 next_state = ST_DONE;
                    else if ({1'b0, n_next} > MAX_WORDS) next_state = ST_ERROR;
                    else                                 next_state = ST_DATA;
                end else if (timed_out) begin
                    next_state = ST_ERROR;
                end
            end
            ST_DATA: begin
                if (accept && asm_full) next_state = ST_WRITE;
                else if (timed_out)     next_state = ST_ERROR;
            end
            ST_WRITE: begin
                // Compare against the post-increment count so the last word ends the load.
                if (17'(wcount) + 17'd1 == {1'b0, n_words}) next_state = ST_DONE;
                else                                        next_state = ST_DATA;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            n_hi    <= '0;
            n_words <= '0;
            wcount  <= '0;
            tcnt    <= '0;
        end else begin
            state <= next_state;
            if (restart || accept || timed_out)
                tcnt <= '0;
            else if (idle_tick)
                tcnt <= tcnt + 1'b1;
            if (restart) begin
                n_words <= '0;
                wcount  <= '0;
            end
            if (accept && state == ST_HDR_HI)
                n_hi <= byte_in;
            if (accept && state == ST_HDR_LO)
                n_words <= n_next;
            if (state == ST_WRITE)
                wcount <= wcount + 1'b1;
        end
    end

    assign byte_ready   = in_load;
    assign imem_we      = (state == ST_WRITE);
    assign imem_addr    = imem_we ? wcount[ADDR_WIDTH-1:0] : '0;
    assign imem_wdata   = imem_we ? asm_word : '0;
    assign cpu_run      = (state == ST_DONE);
    assign done         = (state == ST_DONE);
    assign error        = (state == ST_ERROR);
    assign busy         = in_load || (state == ST_WRITE);
    assign words_loaded = wcount;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    byte_in = 8'h00;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          imem_we;
    logic          cpu_run;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_count = 0;
    int dbl = 0;
    int last_addr = 0;
    int wr_cyc0 = 0;
    int wr_cyc1 = 0;
    logic prev_we = 1'b0;
    logic [31:0] mem [0:1023];

    prog_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .imem_we      (imem_we),
        .cpu_run      (cpu_run),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_we <= imem_we;
        if (imem_we) begin
            mem[imem_addr] <= imem_wdata;
            wr_count       <= wr_count + 1;
            last_addr      <= int'(imem_addr);
            if (imem_addr == 10'd0) wr_cyc0 <= cyc;
            if (imem_addr == 10'd1) wr_cyc1 <= cyc;
            if (prev_we) dbl <= dbl + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        byte_in    = b;
        byte_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) check("send_ready", 32'(byte_ready), 32'd1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    initial begin
        logic [7:0]  prog [0:9];
        logic [31:0] w;
        int          base;
        prog = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_cpu_run", 32'(cpu_run), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'd0);

        // Two-word load, valid held high
        pulse_start();
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_ready", 32'(byte_ready), 32'd1);
        for (int i = 0; i < 6; i++) send(prog[i], 0);
        check("t1_we0", 32'(imem_we), 32'd1);
        check("t1_addr0", 32'(imem_addr), 32'd0);
        check("t1_wdata0", imem_wdata, 32'h2008_0005);
        check("t1_ready_wr", 32'(byte_ready), 32'd0);
        for (int i = 6; i < 10; i++) send(prog[i], 0);
        check("t1_addr1", 32'(imem_addr), 32'd1);
        check("t1_wdata1", imem_wdata, 32'h0000_000C);
        @(posedge clk);
        #1;
        check("t1_done", 32'(done), 32'd1);
        check("t1_cpu_run", 32'(cpu_run), 32'd1);
        check("t1_busy_done", 32'(busy), 32'd0);
        check("t1_words", 32'(words_loaded), 32'd2);
        check("t1_mem0", mem[0], 32'h2008_0005);
        check("t1_mem1", mem[1], 32'h0000_000C);
        check("t1_wr_count", 32'(wr_count), 32'd2);
        check("t1_single_pulse", 32'(dbl), 32'd0);
        check("t1_rate", 32'(wr_cyc1 - wr_cyc0), 32'd5);

        // Restart from DONE, then empty program
        pulse_start();
        check("t2_cpu_run", 32'(cpu_run), 32'd0);
        check("t2_done", 32'(done), 32'd0);
        check("t2_ready", 32'(byte_ready), 32'd1);
        check("t2_words", 32'(words_loaded), 32'd0);
        send(8'h00, 0);
        send(8'h00, 0);
        check("t2_done_n0", 32'(done), 32'd1);
        check("t2_cpu_run_n0", 32'(cpu_run), 32'd1);
        check("t2_no_write", 32'(wr_count), 32'd2);

        // Oversized header
        pulse_start();
        send(8'h04, 0);
        send(8'h01, 0);
        check("t3_error", 32'(error), 32'd1);
        check("t3_cpu_run", 32'(cpu_run), 32'd0);
        check("t3_ready", 32'(byte_ready), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_no_write", 32'(wr_count), 32'd2);

        // Full-capacity load of 1024 words, word i = i
        pulse_start();
        check("t4_error_clr", 32'(error), 32'd0);
        base = wr_count;
        send(8'h04, 0);
        send(8'h00, 0);
        for (int i = 0; i < 1024; i++) begin
            w = 32'(i);
            send(w[31:24], 0);
            send(w[23:16], 0);
            send(w[15:8], 0);
            send(w[7:0], 0);
        end
        check("t4_last_addr", 32'(imem_addr), 32'h3FF);
        check("t4_last_wdata", imem_wdata, 32'h3FF);
        @(posedge clk);
        #1;
        check("t4_done", 32'(done), 32'd1);
        check("t4_words", 32'(words_loaded), 32'd1024);
        check("t4_wr_count", 32'(wr_count - base), 32'd1024);
        check("t4_mem3ff", mem[1023], 32'h3FF);
        check("t4_mem200", mem[512], 32'h200);
        check("t4_last_mon", 32'(last_addr), 32'h3FF);

        // Two-word load with random valid gaps
        pulse_start();
        for (int i = 0; i < 10; i++) send(prog[i], int'($urandom_range(0, 7)));
        @(posedge clk);
        #1;
        check("t5_done", 32'(done), 32'd1);
        check("t5_words", 32'(words_loaded), 32'd2);
        check("t5_mem0", mem[0], 32'h2008_0005);
        check("t5_mem1", mem[1], 32'h0000_000C);

        // Stall mid-word until timeout
        pulse_start();
        base = wr_count;
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        repeat (15) @(posedge clk);
        #1;
        check("t6_no_err_15", 32'(error), 32'd0);
        check("t6_busy_15", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check("t6_err_16", 32'(error), 32'd1);
        check("t6_ready", 32'(byte_ready), 32'd0);
        check("t6_no_write", 32'(wr_count - base), 32'd0);

        // Reset after the third byte of a word
        pulse_start();
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'hAA, 0);
        send(8'hBB, 0);
        send(8'hCC, 0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("t7_ready", 32'(byte_ready), 32'd0);
        check("t7_we", 32'(imem_we), 32'd0);
        check("t7_cpu_run", 32'(cpu_run), 32'd0);
        check("t7_busy", 32'(busy), 32'd0);
        check("t7_done", 32'(done), 32'd0);
        check("t7_error", 32'(error), 32'd0);
        check("t7_words", 32'(words_loaded), 32'd0);
        check("t7_addr", 32'(imem_addr), 32'd0);
        check("t7_wdata", imem_wdata, 32'd0);
        pulse_start();
        check("t7_restart_busy", 32'(busy), 32'd1);
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'h12, 0);
        send(8'h34, 0);
        send(8'h56, 0);
        send(8'h78, 0);
        check("t7_we_fresh", 32'(imem_we), 32'd1);
        check("t7_addr_fresh", 32'(imem_addr), 32'd0);
        check("t7_wdata_fresh", imem_wdata, 32'h1234_5678);
        @(posedge clk);
        #1;
        check("t7_done_fresh", 32'(done), 32'd1);
        check("t7_words_fresh", 32'(words_loaded), 32'd1);
        check("t7_mem0", mem[0], 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1);
    end

endmodule
